uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 166 ++++++++++++++++
 tb/tb_uart_rx.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receive engine: 2-FF input sync, mid-bit sampling, byte strobe and per-frame error strobes.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       busy_o
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV) + 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t        state;
    logic          rx_m;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic par_err_q;
    assign parity_err_o = par_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_i;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            rx_data_o   <= '0;
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
            busy_o      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad     <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state <= DATA;
                            idx   <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == DIV_LAST) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[7:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == DIV_LAST) begin
                        cnt     <= '0;
                        par_bad <= ^{shift, rx_s};
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        // Frame error wins over parity; the line must return high before re-arming.
                        if (!rx_s) begin
                            frame_err_o <= 1'b1;
                            state       <= BREAK;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                par_err_q <= 1'b1;
                            end else begin
                                rx_data_o  <= shift;
                                rx_valid_o <= 1'b1;
                            end
`else
                            rx_data_o  <= shift;
                            rx_valid_o <= 1'b1;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: frames built from start/data/stop bits, decoded by a frame-level model.
module tb_uart_rx;

    localparam int CLK_HZ = 50000000;
    localparam int BAUD   = 1000000;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int HALF   = DIV / 2;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    uart_rx #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .rx_i        (rx),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .frame_err_o (frame_err),
        .parity_err_o(parity_err),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Observed strobes
    logic [7:0]  got_q[$];
    int unsigned ferr_n = 0;
    int unsigned perr_n = 0;

    // Frame-level reference
    logic [7:0]  exp_q[$];
    int unsigned exp_ferr = 0;
    logic [7:0]  exp_last = 8'h00;
    int unsigned seen     = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid)   got_q.push_back(rx_data);
            if (frame_err)  ferr_n++;
            if (parity_err) perr_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [9:0] frame, input int unsigned nbits);
        for (int unsigned i = 0; i < nbits; i++) begin
            rx = frame[i];
            repeat (DIV) @(negedge clk);
        end
    endtask

    // A frame is good iff its stop bit is high; data is the 8 bits after start, LSB first.
    task automatic send_byte(input logic [7:0] d, input logic stop);
        logic [9:0] frame;
        frame = {stop, d, 1'b0};
        send_bits(frame, 10);
        if (frame[9]) begin
            exp_q.push_back(frame[8:1]);
            exp_last = frame[8:1];
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic checkpoint(input string tag);
        check({tag, ".count"}, got_q.size(), exp_q.size());
        while (seen < exp_q.size() && seen < got_q.size()) begin
            check({tag, ".data"}, got_q[seen], exp_q[seen]);
            seen++;
        end
        seen = exp_q.size();
        check({tag, ".ferr"}, ferr_n, exp_ferr);
        check({tag, ".perr"}, perr_n, 0);
        check({tag, ".hold"}, rx_data, exp_last);
        check({tag, ".busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [7:0]  d;
        logic        stop;
        int unsigned gap;

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check("rst.data",  rx_data, 8'h00);
        check("rst.valid", rx_valid, 1'b0);
        check("rst.ferr",  frame_err, 1'b0);
        check("rst.perr",  parity_err, 1'b0);
        check("rst.busy",  busy, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_byte(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        checkpoint("a5");

        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        checkpoint("b2b");

        // Glitch shorter than half a bit: busy rises, then drops at the start-bit check
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch.busy_hi", busy, 1'b1);
        repeat (HALF) @(negedge clk);
        checkpoint("glitch");

        send_byte(8'h3C, 1'b0);
        repeat (2 * DIV) @(negedge clk);
        check("break.busy_hi", busy, 1'b1);
        check("break.ferr", ferr_n, exp_ferr);
        check("break.hold", rx_data, exp_last);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        checkpoint("break");
        send_byte(8'h55, 1'b1);
        checkpoint("after_break");

        // Reset in the middle of data bit 4; the truncated frame must vanish
        send_bits({1'b1, 8'hF0, 1'b0}, 5);
        repeat (HALF) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst.data",  rx_data, 8'h00);
        check("midrst.valid", rx_valid, 1'b0);
        check("midrst.busy",  busy, 1'b0);
        rx       = 1'b1;
        exp_last = 8'h00;
        rst_n    = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        checkpoint("midrst");
        send_byte(8'h81, 1'b1);
        checkpoint("after_rst");

        for (int i = 0; i < 30; i++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            gap  = $urandom_range(0, 2 * DIV);
            send_byte(d, stop);
            if (!stop) begin
                repeat ($urandom_range(0, DIV)) @(negedge clk);
                rx = 1'b1;
                repeat (4) @(negedge clk);
            end
            checkpoint("rand");
            repeat (gap) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
